// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and helpers for the universal shift register.
//   shift_mode_t : encoding of the 2-bit mode input
//   cnt_width()  : width of a counter that must hold 0..w inclusive
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        SM_HOLD = 2'b00,
        SM_SHR  = 2'b01,
        SM_SHL  = 2'b10,
        SM_LOAD = 2'b11
    } shift_mode_t;

    // The frame counter saturates at w, so it needs room for w itself.
    function automatic int cnt_width(int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// ---------------------------------------------------------------------------
// shift_frame_counter
// Saturating count of shifts since the last load/reset, with a one-cycle
// registered pulse on the shift that brings the count up to WIDTH.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   inc   in   a qualified shift happens this cycle
//   clr   in   a qualified parallel load happens this cycle
//   cnt   out  shifts since last clear, saturating at WIDTH
//   done  out  high for one cycle when cnt reaches WIDTH
// ---------------------------------------------------------------------------
module shift_frame_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            // The pulse is a single cycle: default low every edge.
            done <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt < CNT_MAX)) begin
                cnt  <= cnt + 1'b1;
                done <= (cnt == CNT_LAST);
            end
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
// Parametrised hold / shift-right / shift-left / parallel-load register with
// clock enable, bidirectional serial I/O and a frame counter that flags when
// WIDTH bits have been shifted since the last load.
//
// Build option: define SHIFT_ROTATE_EN to make rot=1 feed the outgoing bit
// back in as the serial input (rotate). Without it, rot is ignored.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (overrides en/mode)
//   en          in   clock enable
//   mode        in   00 hold, 01 shift right, 10 shift left, 11 load
//   sin_msb     in   serial in to q[WIDTH-1] on shift right
//   sin_lsb     in   serial in to q[0] on shift left
//   rot         in   rotate select (SHIFT_ROTATE_EN builds only)
//   pdata_in    in   parallel load data
//   q           out  register contents
//   sout_lsb    out  q[0]
//   sout_msb    out  q[WIDTH-1]
//   shift_cnt   out  shifts since last load/reset, saturating at WIDTH
//   frame_done  out  one-cycle pulse when shift_cnt reaches WIDTH
// ---------------------------------------------------------------------------
module universal_shift_register
    import shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W       = cnt_width(WIDTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             rot,
    input  logic [WIDTH-1:0] pdata_in,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    if (WIDTH < 2) begin : g_width_check
        $error("universal_shift_register: WIDTH must be >= 2");
    end

    shift_mode_t     mode_e;
    logic            shr_in;
    logic            shl_in;
    logic [WIDTH-1:0] q_next;
    logic            is_shift;
    logic            is_load;

    assign mode_e = shift_mode_t'(mode);

    // Serial input selection; with rotate enabled the outgoing bit wraps.
`ifdef SHIFT_ROTATE_EN
    assign shr_in = rot ? q[0]       : sin_msb;
    assign shl_in = rot ? q[WIDTH-1] : sin_lsb;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign shr_in     = sin_msb;
    assign shl_in     = sin_lsb;
`endif

    always_comb begin
        q_next = q;
        case (mode_e)
            SM_HOLD: q_next = q;
            SM_SHR:  q_next = {shr_in, q[WIDTH-1:1]};
            SM_SHL:  q_next = {q[WIDTH-2:0], shl_in};
            SM_LOAD: q_next = pdata_in;
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign is_shift = en && ((mode_e == SM_SHR) || (mode_e == SM_SHL));
    assign is_load  = en && (mode_e == SM_LOAD);

    shift_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (is_shift),
        .clr  (is_load),
        .cnt  (shift_cnt),
        .done (frame_done)
    );

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, en, sin_msb, sin_lsb, rot;
    logic [1:0]    mode;
    logic [W-1:0]  pdata_in;
    logic [W-1:0]  q;
    logic          sout_lsb, sout_msb, frame_done;
    logic [CW-1:0] shift_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
        .rot        (rot),
        .pdata_in   (pdata_in),
        .q          (q),
        .sout_lsb   (sout_lsb),
        .sout_msb   (sout_msb),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic [1:0]    mode;
        logic          smsb;
        logic          slsb;
        logic          rot;
        logic [W-1:0]  pd;
        logic [W-1:0]  eq;
        logic [CW-1:0] ec;
        logic          ed;
    } vec_t;

    typedef struct {
        logic [W-1:0]  q;
        logic [CW-1:0] c;
        logic          d;
        string         tag;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];

    // Reference model state for the random section.
    logic [W-1:0]  mq;
    logic [CW-1:0] mc;
    logic          md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue the expectation, pop and compare after the edge.
    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic sm, input logic sl, input logic ro,
                         input logic [W-1:0] pd, input exp_t x);
        exp_t got;
        rst = r; en = e; mode = m; sin_msb = sm; sin_lsb = sl; rot = ro; pdata_in = pd;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk({got.tag, ".q"},    32'(q),          32'(got.q));
            chk({got.tag, ".cnt"},  32'(shift_cnt),  32'(got.c));
            chk({got.tag, ".done"}, 32'(frame_done), 32'(got.d));
            chk({got.tag, ".slsb"}, 32'(sout_lsb),   32'(got.q[0]));
            chk({got.tag, ".smsb"}, 32'(sout_msb),   32'(got.q[W-1]));
        end
    endtask

    task automatic addv(input logic r, input logic e, input logic [1:0] m,
                        input logic sm, input logic sl, input logic ro, input logic [W-1:0] pd,
                        input logic [W-1:0] eq, input logic [CW-1:0] ec, input logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.smsb = sm; v.slsb = sl; v.rot = ro; v.pd = pd;
        v.eq = eq; v.ec = ec; v.ed = ed;
        vt.push_back(v);
    endtask

    initial begin
        logic [W-1:0] shr_q [8];
        logic [W-1:0] shl_q [8];
        logic         shl_b [8];
        logic [W-1:0] fill_q [8];
        exp_t x;

        shr_q  = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        shl_b  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        shl_q  = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h19, 8'h32, 8'h65, 8'hCB};
        fill_q = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        // Reset with mode/pdata toggling.
        addv(1, 1, 2'b11, 1, 1, 0, 8'hFF, 8'h00, 0, 0);
        addv(1, 1, 2'b01, 1, 1, 0, 8'hFF, 8'h00, 0, 0);
        // Load A5, 8 shift-rights with sin_msb=0 (pdata/sin_lsb junk ignored).
        addv(0, 1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        for (int i = 0; i < 8; i++)
            addv(0, 1, 2'b01, 0, 1, 0, 8'hFF, shr_q[i], CW'(i + 1), i == 7);
        // Reload zero, 8 shift-lefts to CB, then a saturated 9th shift.
        addv(0, 1, 2'b11, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++)
            addv(0, 1, 2'b10, 1, shl_b[i], 0, 8'hFF, shl_q[i], CW'(i + 1), i == 7);
        addv(0, 1, 2'b10, 1, 0, 0, 8'hFF, 8'h96, 8, 0);
        addv(0, 1, 2'b00, 1, 1, 0, 8'hFF, 8'h96, 8, 0);
        // Load 3C, shift right with en toggling.
        addv(0, 1, 2'b11, 0, 0, 0, 8'h3C, 8'h3C, 0, 0);
        addv(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h1E, 1, 0);
        addv(0, 0, 2'b01, 1, 0, 0, 8'h00, 8'h1E, 1, 0);
        addv(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h0F, 2, 0);
        addv(0, 0, 2'b01, 1, 0, 0, 8'h00, 8'h0F, 2, 0);
        addv(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h07, 3, 0);
        addv(0, 0, 2'b11, 0, 0, 0, 8'hFF, 8'h07, 3, 0);
        // Two more shifts (5 since load), then reset mid-frame.
        addv(0, 1, 2'b01, 1, 0, 0, 8'h00, 8'h83, 4, 0);
        addv(0, 1, 2'b01, 1, 0, 0, 8'h00, 8'hC1, 5, 0);
        addv(1, 1, 2'b01, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++)
            addv(0, 1, 2'b01, 1, 0, 0, 8'h00, fill_q[i], CW'(i + 1), i == 7);
        addv(0, 0, 2'b01, 1, 0, 0, 8'h00, 8'hFF, 8, 0);
        // Rotate vs. plain shift.
        addv(0, 1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 0, 0);
`ifdef SHIFT_ROTATE_EN
        addv(0, 1, 2'b10, 0, 0, 1, 8'h00, 8'h03, 1, 0);
        addv(0, 1, 2'b01, 0, 0, 1, 8'h00, 8'h81, 2, 0);
`else
        addv(0, 1, 2'b10, 0, 0, 1, 8'h00, 8'h02, 1, 0);
        addv(0, 1, 2'b01, 0, 0, 1, 8'h00, 8'h01, 2, 0);
`endif

        for (int i = 0; i < vt.size(); i++) begin
            x.q = vt[i].eq; x.c = vt[i].ec; x.d = vt[i].ed;
            x.tag = $sformatf("vec%0d", i);
            drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].smsb, vt[i].slsb,
                  vt[i].rot, vt[i].pd, x);
        end

        // Randomised traffic against an independent model.
        mq = '0; mc = '0; md = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic r, e, sm, sl, ro, sh;
            logic [1:0] m;
            logic [W-1:0] pd;
            r  = (i == 0) || ($urandom_range(0, 39) == 0);
            e  = $urandom_range(0, 4) != 0;
            m  = $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 3));
            sm = 1'($urandom); sl = 1'($urandom); ro = 1'($urandom);
            pd = W'($urandom);
            md = 1'b0;
            sh = 1'b0;
            if (r) begin
                mq = '0; mc = '0;
            end else if (e) begin
                case (m)
                    2'b01: begin
`ifdef SHIFT_ROTATE_EN
                        if (ro) sm = mq[0];
`endif
                        mq = {sm, mq[W-1:1]}; sh = 1'b1;
                    end
                    2'b10: begin
`ifdef SHIFT_ROTATE_EN
                        if (ro) sl = mq[W-1];
`endif
                        mq = {mq[W-2:0], sl}; sh = 1'b1;
                    end
                    2'b11: begin mq = pd; mc = '0; end
                    default: ;
                endcase
                if (sh && mc < CW'(W)) begin
                    mc = mc + 1'b1;
                    md = (mc == CW'(W));
                end
            end
            x.q = mq; x.c = mc; x.d = md;
            x.tag = $sformatf("rnd%0d", i);
            // Undo the rotate substitution so the DUT sees the raw serial bit
            // only matters for rotate builds; driving the substituted bit is
            // equivalent since rot=1 ignores sin_*.
            drive(r, e, m, sm, sl, ro, pd, x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
